// File: rtl/rom_search_unit.sv
// ---------------------------------------------------------------------------
// rom_search_unit
//
// Purpose:
//   Sequential search controller placed directly upstream of a MaskROM.
//   On a start request it sweeps the ROM addresses in ascending order and
//   compares each word against a search key that was latched with start.
//   It reports whether a match was found, the first matching address and
//   the total number of matching words. A start/busy/done handshake faces
//   the system-level controller.
//
// Optional feature (macro ROM_SEARCH_MASK_EN):
//   When defined, the key_mask port exists and is latched with start. The
//   match test becomes (rom_data & mask) == (key & mask). A zero mask
//   therefore matches every word. When the macro is not defined, an exact
//   compare is used.
//
// Ports:
//   CLK          in   system clock, rising edge
//   RST_N        in   asynchronous reset, active low
//   start        in   begin a new search (accepted only in IDLE)
//   stop_first   in   1 = finish at the first match (latched with start)
//   key          in   search key (latched with start)
//   key_mask     in   compare mask (only with ROM_SEARCH_MASK_EN)
//   rom_addr     out  address to the MaskROM
//   rom_data     in   combinational ROM data for rom_addr
//   busy         out  high while scanning
//   done         out  one-cycle pulse when the search completes
//   found        out  at least one match in the last search
//   first_addr   out  address of the first match (valid when found=1)
//   match_count  out  number of matching words in the last search
// ---------------------------------------------------------------------------
module rom_search_unit #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int CNT_W  = ADDR_W + 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              start,
  input  logic              stop_first,
  input  logic [DATA_W-1:0] key,
`ifdef ROM_SEARCH_MASK_EN
  input  logic [DATA_W-1:0] key_mask,
`endif
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [ADDR_W-1:0] first_addr,
  output logic [CNT_W-1:0]  match_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state_q,  state_d;
  logic [ADDR_W-1:0]   addr_q,   addr_d;
  logic                found_q,  found_d;
  logic [ADDR_W-1:0]   first_q,  first_d;
  logic [CNT_W-1:0]    count_q,  count_d;
  logic [DATA_W-1:0]   key_q,    key_d;
  logic                stop_q,   stop_d;
  logic                hit;
  logic                last_addr;

`ifdef ROM_SEARCH_MASK_EN
  logic [DATA_W-1:0]   mask_q,   mask_d;

  assign hit = ((rom_data & mask_q) == (key_q & mask_q));
`else
  assign hit = (rom_data == key_q);
`endif

  assign last_addr = (addr_q == {ADDR_W{1'b1}});

  // Next-state and result update logic.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    addr_d  = addr_q;
    found_d = found_q;
    first_d = first_q;
    count_d = count_q;
    key_d   = key_q;
    stop_d  = stop_q;
`ifdef ROM_SEARCH_MASK_EN
    mask_d  = mask_q;
`endif

    unique case (state_q)
      IDLE: begin
        // Previous results stay visible until the next accepted start.
        if (start) begin
          key_d   = key;
          stop_d  = stop_first;
`ifdef ROM_SEARCH_MASK_EN
          mask_d  = key_mask;
`endif
          found_d = 1'b0;
          first_d = '0;
          count_d = '0;
          addr_d  = '0;
          state_d = SCAN;
        end
      end

      SCAN: begin
        if (hit) begin
          count_d = count_q + CNT_W'(1);
          if (!found_q) begin
            found_d = 1'b1;
            first_d = addr_q;
          end
        end
        // The address never wraps: the last word ends the sweep and the
        // final address is held through DONE.
        if (last_addr || (stop_q && hit)) begin
          state_d = DONE;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      addr_q  <= '0;
      found_q <= 1'b0;
      first_q <= '0;
      count_q <= '0;
      key_q   <= '0;
      stop_q  <= 1'b0;
`ifdef ROM_SEARCH_MASK_EN
      mask_q  <= '0;
`endif
    end else begin
      // NOTE: state registers use non-blocking assignments so all of them
      // update together from the values present before the edge.
      state_q <= state_d;
      addr_q  <= addr_d;
      found_q <= found_d;
      first_q <= first_d;
      count_q <= count_d;
      key_q   <= key_d;
      stop_q  <= stop_d;
`ifdef ROM_SEARCH_MASK_EN
      mask_q  <= mask_d;
`endif
    end
  end

  assign rom_addr    = addr_q;
  assign busy        = (state_q == SCAN);
  assign done        = (state_q == DONE);
  assign found       = found_q;
  assign first_addr  = first_q;
  assign match_count = count_q;

endmodule

// File: tb/tb_rom_search_unit.sv
// ---------------------------------------------------------------------------
// tb_rom_search_unit
//
// Directed bench for rom_search_unit with the default 16-word, 8-bit ROM.
// A combinational ROM model drives rom_data from rom_addr. Its contents:
//   0:00 1:11 2:22 3:33 4:44 5:55 6:66 7:77
//   8:88 9:A3 10:A6 11:BB 12:CC 13:DD 14:EE 15:5A
// so A6 matches only address 10, 00 only address 0, 5A only address 15,
// FF nowhere, and A0 under mask F0 matches addresses 9 and 10.
// Outputs are sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_rom_search_unit;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int CNT_W  = ADDR_W + 1;
  localparam int LIMIT  = 40;

  logic              CLK;
  logic              RST_N;
  logic              start;
  logic              stop_first;
  logic [DATA_W-1:0] key;
`ifdef ROM_SEARCH_MASK_EN
  logic [DATA_W-1:0] key_mask;
`endif
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              busy;
  logic              done;
  logic              found;
  logic [ADDR_W-1:0] first_addr;
  logic [CNT_W-1:0]  match_count;

  logic [DATA_W-1:0] rom_mem [16];

  int checks = 0;
  int errors = 0;

  rom_search_unit #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .CNT_W (CNT_W)
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .start      (start),
    .stop_first (stop_first),
    .key        (key),
`ifdef ROM_SEARCH_MASK_EN
    .key_mask   (key_mask),
`endif
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .busy       (busy),
    .done       (done),
    .found      (found),
    .first_addr (first_addr),
    .match_count(match_count)
  );

  assign rom_data = rom_mem[rom_addr];

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_rom();
    rom_mem[0]  = 8'h00; rom_mem[1]  = 8'h11; rom_mem[2]  = 8'h22; rom_mem[3]  = 8'h33;
    rom_mem[4]  = 8'h44; rom_mem[5]  = 8'h55; rom_mem[6]  = 8'h66; rom_mem[7]  = 8'h77;
    rom_mem[8]  = 8'h88; rom_mem[9]  = 8'hA3; rom_mem[10] = 8'hA6; rom_mem[11] = 8'hBB;
    rom_mem[12] = 8'hCC; rom_mem[13] = 8'hDD; rom_mem[14] = 8'hEE; rom_mem[15] = 8'h5A;
  endtask

  task automatic check_results(input string tag, input logic f,
                               input logic [ADDR_W-1:0] fa, input logic [CNT_W-1:0] mc);
    check({tag, ".found"},       32'(found),       32'(f));
    check({tag, ".first_addr"},  32'(first_addr),  32'(fa));
    check({tag, ".match_count"}, 32'(match_count), 32'(mc));
  endtask

  // Pulses start (called just after an edge) and waits for done.
  // lat is the cycle index of done relative to the start edge (cycle k+lat);
  // nbusy counts cycles with busy high before done.
  task automatic run_search(input string tag, input logic [DATA_W-1:0] k,
                            input logic sf, output int lat, output int nbusy);
    key        = k;
    stop_first = sf;
    start      = 1'b1;
    step();
    start = 1'b0;
    lat   = 1;
    nbusy = 0;
    while (!done && lat < LIMIT) begin
      if (busy) nbusy++;
      step();
      lat++;
    end
    check({tag, ".done_seen"}, 32'(done), 32'd1);
    check({tag, ".busy_in_done"}, 32'(busy), 32'd0);
  endtask

  int lat;
  int nbusy;

  initial begin
    load_rom();
    RST_N      = 1'b1;
    start      = 1'b0;
    stop_first = 1'b0;
    key        = '0;
`ifdef ROM_SEARCH_MASK_EN
    key_mask   = 8'hFF;
`endif

    // Reset state.
    #2 RST_N = 1'b0;
    #2;
    check("rst.rom_addr", 32'(rom_addr), 32'd0);
    check("rst.busy",     32'(busy),     32'd0);
    check("rst.done",     32'(done),     32'd0);
    check_results("rst", 1'b0, '0, '0);
    step();
    step();
    RST_N = 1'b1;
    step();

    // Full sweep with key A6: address sequence, latency, results.
    key        = 8'hA6;
    stop_first = 1'b0;
    start      = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("a6.addr%0d", i), 32'(rom_addr), 32'(i));
      check($sformatf("a6.busy%0d", i), 32'(busy), 32'd1);
      check($sformatf("a6.done%0d", i), 32'(done), 32'd0);
      step();
    end
    // Now in cycle k+17.
    check("a6.done_k17", 32'(done), 32'd1);
    check("a6.busy_k17", 32'(busy), 32'd0);
    check("a6.addr_hold", 32'(rom_addr), 32'd15);
    check_results("a6", 1'b1, 4'd10, 5'd1);
    step();
    check("a6.done_pulse", 32'(done), 32'd0);
    check("a6.idle_busy",  32'(busy), 32'd0);
    step();
    step();
    check_results("a6.held", 1'b1, 4'd10, 5'd1);

    // No match anywhere: busy exactly 16 cycles, done at k+17.
    run_search("ff", 8'hFF, 1'b0, lat, nbusy);
    check("ff.latency", 32'(lat),   32'd17);
    check("ff.nbusy",   32'(nbusy), 32'd16);
    check_results("ff", 1'b0, '0, '0);

    // start while done is high is ignored.
    start = 1'b1;
    key   = 8'h00;
    step();
    start = 1'b0;
    check("start_in_done.busy", 32'(busy), 32'd0);
    check("start_in_done.done", 32'(done), 32'd0);
    step();
    check("start_in_done.busy2", 32'(busy), 32'd0);
    check_results("start_in_done", 1'b0, '0, '0);

    // stop_first with a match at address 0.
    run_search("stop0", 8'h00, 1'b1, lat, nbusy);
    check("stop0.latency",  32'(lat),      32'd2);
    check("stop0.addr",     32'(rom_addr), 32'd0);
    check_results("stop0", 1'b1, 4'd0, 5'd1);
    step();

    // stop_first with the only match at the last address.
    run_search("stop15", 8'h5A, 1'b1, lat, nbusy);
    check("stop15.latency", 32'(lat),      32'd17);
    check("stop15.addr",    32'(rom_addr), 32'd15);
    check_results("stop15", 1'b1, 4'd15, 5'd1);
    step();

    // Reset mid-scan at address 7: immediate clear, no done, clean restart.
    key        = 8'hA6;
    stop_first = 1'b0;
    start      = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 7; i++) step();
    check("abort.addr7", 32'(rom_addr), 32'd7);
    check("abort.busy7", 32'(busy),     32'd1);
    #1 RST_N = 1'b0;
    #1;
    check("abort.rom_addr", 32'(rom_addr), 32'd0);
    check("abort.busy",     32'(busy),     32'd0);
    check("abort.done",     32'(done),     32'd0);
    check_results("abort", 1'b0, '0, '0);
    step();
    check("abort.no_done", 32'(done), 32'd0);
    RST_N = 1'b1;
    step();
    check("abort.idle_done", 32'(done), 32'd0);
    check("abort.idle_busy", 32'(busy), 32'd0);
    run_search("after_abort", 8'hA6, 1'b0, lat, nbusy);
    check("after_abort.latency", 32'(lat),   32'd17);
    check("after_abort.nbusy",   32'(nbusy), 32'd16);
    check_results("after_abort", 1'b1, 4'd10, 5'd1);
    step();

    // start re-pulsed mid-scan with a different key is ignored.
    key   = 8'hA6;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) step();
    start = 1'b1;
    key   = 8'h00;
    step();
    start = 1'b0;
    check("restart.addr", 32'(rom_addr), 32'd6);
    check("restart.busy", 32'(busy),     32'd1);
    lat = 0;
    while (!done && lat < LIMIT) begin
      step();
      lat++;
    end
    check("restart.done_seen", 32'(done), 32'd1);
    check_results("restart", 1'b1, 4'd10, 5'd1);
    step();

    // Every word matches: the counter reaches 16 without overflow.
    for (int i = 0; i < 16; i++) rom_mem[i] = 8'h3C;
    run_search("all", 8'h3C, 1'b0, lat, nbusy);
    check("all.latency", 32'(lat), 32'd17);
    check_results("all", 1'b1, 4'd0, 5'd16);
    load_rom();
    step();

`ifdef ROM_SEARCH_MASK_EN
    // Masked compare: upper nibble A matches addresses 9 and 10.
    key_mask = 8'hF0;
    run_search("mask", 8'hA0, 1'b0, lat, nbusy);
    check_results("mask", 1'b1, 4'd9, 5'd2);
    step();
    // Zero mask matches every word.
    key_mask = 8'h00;
    run_search("mask0", 8'h5A, 1'b0, lat, nbusy);
    check_results("mask0", 1'b1, 4'd0, 5'd16);
    key_mask = 8'hFF;
    step();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
